// File: rtl/icache_direct_if.sv
// Fetch-side and refill-side handshake bundle for the direct-mapped instruction cache.
// The slave modport is the cache; the master modport is the fetch stage plus the read master.
interface icache_direct_if #(
    parameter int LINE_WORDS = 4
);
    logic                     cpu_req_valid;
    logic [31:0]              cpu_req_addr;
    logic                     cpu_ready;
    logic                     cpu_resp_valid;
    logic [31:0]              cpu_resp_data;
    logic                     flush;
    logic                     refill_req_valid;
    logic [31:0]              refill_req_addr;
    logic                     refill_resp_valid;
    logic [LINE_WORDS*32-1:0] refill_resp_data;

    modport master (
        output cpu_req_valid, cpu_req_addr, flush, refill_resp_valid, refill_resp_data,
        input  cpu_ready, cpu_resp_valid, cpu_resp_data, refill_req_valid, refill_req_addr
    );

    modport slave (
        input  cpu_req_valid, cpu_req_addr, flush, refill_resp_valid, refill_resp_data,
        output cpu_ready, cpu_resp_valid, cpu_resp_data, refill_req_valid, refill_req_addr
    );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache, one outstanding fetch, blocking on miss.
// state     | meaning
// IDLE      | ready for a fetch; flush clears all valid bits
// LOOKUP    | compare stored tag for the latched address
// MISS_REQ  | single-cycle refill request to the read master
// MISS_WAIT | wait for the refill line, install it and answer the fetch
module icache_direct #(
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 16
) (
    input logic            clk,
    input logic            rst,
    icache_direct_if.slave bus
);
    localparam int ADDR_WIDTH = 32;
    localparam int OFF_W      = $clog2(LINE_WORDS);
    localparam int IDX_W      = $clog2(NUM_LINES);
    localparam int TAG_W      = ADDR_WIDTH - 2 - OFF_W - IDX_W;
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(LINE_WORDS * 4 - 1);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_LOOKUP    = 2'd1;
    localparam logic [1:0] S_MISS_REQ  = 2'd2;
    localparam logic [1:0] S_MISS_WAIT = 2'd3;

    logic [1:0]               state;
    logic [ADDR_WIDTH-1:0]    addr_reg;
    logic [NUM_LINES-1:0]     valid;
    logic [TAG_W-1:0]         tag_mem  [NUM_LINES];
    logic [LINE_WORDS*32-1:0] data_mem [NUM_LINES];

    logic [OFF_W-1:0] off;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [OFF_W+4:0] word_lsb;
    logic             hit;
    logic             refill_done;

    assign off         = addr_reg[2 +: OFF_W];
    assign idx         = addr_reg[2+OFF_W +: IDX_W];
    assign tag         = addr_reg[ADDR_WIDTH-1 -: TAG_W];
    assign word_lsb    = {off, 5'b0};
    assign hit         = valid[idx] && (tag_mem[idx] == tag);
    assign refill_done = (state == S_MISS_WAIT) && bus.refill_resp_valid;

    assign bus.cpu_ready = (state == S_IDLE) && !bus.flush;

    // Line storage needs no reset: every read is qualified by its valid bit.
    always_ff @(posedge clk) begin
        if (!rst && refill_done) begin
            tag_mem[idx]  <= tag;
            data_mem[idx] <= bus.refill_resp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= S_IDLE;
            valid                <= '0;
            addr_reg             <= '0;
            bus.cpu_resp_valid   <= 1'b0;
            bus.cpu_resp_data    <= '0;
            bus.refill_req_valid <= 1'b0;
            bus.refill_req_addr  <= '0;
        end else begin
            bus.cpu_resp_valid   <= 1'b0;
            bus.refill_req_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.flush) begin
                        valid <= '0;
                    end else if (bus.cpu_req_valid) begin
                        addr_reg <= bus.cpu_req_addr;
                        state    <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (hit) begin
                        bus.cpu_resp_data  <= data_mem[idx][word_lsb +: 32];
                        bus.cpu_resp_valid <= 1'b1;
                        state              <= S_IDLE;
                    end else begin
                        // Registered so the pulse lands exactly in the MISS_REQ cycle.
                        bus.refill_req_valid <= 1'b1;
                        bus.refill_req_addr  <= addr_reg & ~LINE_MASK;
                        state                <= S_MISS_REQ;
                    end
                end
                S_MISS_REQ: begin
                    state <= S_MISS_WAIT;
                end
                S_MISS_WAIT: begin
                    if (bus.refill_resp_valid) begin
                        valid[idx]         <= 1'b1;
                        bus.cpu_resp_data  <= bus.refill_resp_data[word_lsb +: 32];
                        bus.cpu_resp_valid <= 1'b1;
                        state              <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_icache_direct.sv
// Directed bench for icache_direct: a line-level cache model predicts hit/miss, refill
// addresses and response timing; a negedge monitor compares the DUT every cycle.
module tb_icache_direct;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    icache_direct_if #(.LINE_WORDS(4)) bus();
    icache_direct #(.LINE_WORDS(4), .NUM_LINES(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int          cyc;
        logic [31:0] val;
    } exp_t;

    exp_t        resp_q[$];
    exp_t        refill_q[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic        mon_en = 1'b0;
    logic        model_valid [16];
    logic [23:0] model_tag   [16];
    logic [31:0] last_resp = '0;
    logic [31:0] last_refill = '0;
    int          resp_cnt = 0;
    int          refill_cnt = 0;
    logic        e_resp, e_refill;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Backing memory: every word is a distinct, easily hand-computed pattern.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hC0DE, a[15:2], 2'b00};
    endfunction

    function automatic logic [127:0] mem_line(input logic [31:0] line);
        logic [127:0] ld;
        for (int w = 0; w < 4; w++) ld[w*32 +: 32] = mem_word(line + 32'(w * 4));
        return ld;
    endfunction

    task automatic model_invalidate();
        for (int i = 0; i < 16; i++) model_valid[i] = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            e_resp = (resp_q.size() > 0) && (resp_q[0].cyc == cyc);
            chk("cpu_resp_valid", 32'(bus.cpu_resp_valid), 32'(e_resp));
            if (e_resp) begin
                chk("cpu_resp_data", bus.cpu_resp_data, resp_q[0].val);
                void'(resp_q.pop_front());
            end
            if (bus.cpu_resp_valid) begin
                last_resp = bus.cpu_resp_data;
                resp_cnt++;
            end
            e_refill = (refill_q.size() > 0) && (refill_q[0].cyc == cyc);
            chk("refill_req_valid", 32'(bus.refill_req_valid), 32'(e_refill));
            if (e_refill) begin
                chk("refill_req_addr", bus.refill_req_addr, refill_q[0].val);
                void'(refill_q.pop_front());
            end
            if (bus.refill_req_valid) begin
                last_refill = bus.refill_req_addr;
                refill_cnt++;
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (bus.cpu_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("cpu_ready_wait", 32'(bus.cpu_ready), 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while ((resp_q.size() > 0 || refill_q.size() > 0) && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (n >= 30) begin
            chk("drain_timeout", 32'(resp_q.size() + refill_q.size()), 32'd0);
            resp_q.delete();
            refill_q.delete();
        end
        @(negedge clk);
    endtask

    // One fetch; on a predicted miss the bench plays the read master, answering
    // `delay` cycles after the request state, optionally with a stray fetch meanwhile.
    task automatic fetch(input logic [31:0] a, input int delay, input bit stray);
        int          t0, tr;
        logic [31:0] line;
        logic [3:0]  idx;
        logic [23:0] tg;
        bit          miss;
        line = a & 32'hFFFF_FFF0;
        idx  = a[7:4];
        tg   = a[31:8];
        miss = !(model_valid[idx] && model_tag[idx] == tg);
        wait_ready();
        t0 = cyc + 1;
        bus.cpu_req_valid = 1'b1;
        bus.cpu_req_addr  = a;
        tr = t0 + 2 + delay;
        if (miss) begin
            refill_q.push_back(exp_t'{cyc: t0 + 1, val: line});
            resp_q.push_back(exp_t'{cyc: tr, val: mem_word(a)});
            model_valid[idx] = 1'b1;
            model_tag[idx]   = tg;
        end else begin
            resp_q.push_back(exp_t'{cyc: t0 + 1, val: mem_word(a)});
        end
        @(negedge clk);
        bus.cpu_req_valid = 1'b0;
        if (miss) begin
            if (stray) begin
                while (cyc < t0 + 2) @(negedge clk);
                bus.cpu_req_valid = 1'b1;
                bus.cpu_req_addr  = 32'h0000_2000;
            end
            while (cyc < tr - 1) @(negedge clk);
            bus.cpu_req_valid     = 1'b0;
            bus.refill_resp_valid = 1'b1;
            bus.refill_resp_data  = mem_line(line);
            @(negedge clk);
            bus.refill_resp_valid = 1'b0;
            bus.refill_resp_data  = '0;
        end
        drain();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        rst = 1'b1;
        bus.cpu_req_valid     = 1'b0;
        bus.cpu_req_addr      = '0;
        bus.flush             = 1'b0;
        bus.refill_resp_valid = 1'b0;
        bus.refill_resp_data  = '0;
        model_invalidate();
        for (int i = 0; i < 16; i++) model_tag[i] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_cpu_ready", 32'(bus.cpu_ready), 32'd1);
        chk("reset_resp_valid", 32'(bus.cpu_resp_valid), 32'd0);
        chk("reset_resp_data", bus.cpu_resp_data, 32'h0);
        chk("reset_refill_valid", 32'(bus.refill_req_valid), 32'd0);
        chk("reset_refill_addr", bus.refill_req_addr, 32'h0);
        mon_en = 1'b1;

        // Cold miss, then hit in the same line.
        fetch(32'h0000_0104, 2, 1'b0);
        chk("cold_refill_addr", last_refill, 32'h0000_0100);
        chk("cold_resp_data", last_resp, 32'hC0DE_0104);
        chk("cold_resp_cnt", 32'(resp_cnt), 32'd1);
        chk("cold_refill_cnt", 32'(refill_cnt), 32'd1);
        fetch(32'h0000_010C, 0, 1'b0);
        chk("hit_resp_data", last_resp, 32'hC0DE_010C);
        chk("hit_refill_cnt", 32'(refill_cnt), 32'd1);

        // Conflict eviction on index 0.
        fetch(32'h0000_1100, 1, 1'b0);
        chk("conflict_refill_addr", last_refill, 32'h0000_1100);
        chk("conflict_resp_data", last_resp, 32'hC0DE_1100);
        fetch(32'h0000_0100, 3, 1'b0);
        chk("refetch_refill_cnt", 32'(refill_cnt), 32'd3);
        chk("refetch_resp_data", last_resp, 32'hC0DE_0100);

        // Flush wins over a simultaneous request.
        bus.flush         = 1'b1;
        bus.cpu_req_valid = 1'b1;
        bus.cpu_req_addr  = 32'h0000_0100;
        #1;
        chk("flush_cpu_ready", 32'(bus.cpu_ready), 32'd0);
        @(negedge clk);
        bus.flush         = 1'b0;
        bus.cpu_req_valid = 1'b0;
        model_invalidate();
        repeat (3) @(negedge clk);
        chk("flush_no_accept_resp", 32'(resp_cnt), 32'd4);
        fetch(32'h0000_0104, 1, 1'b0);
        chk("flush_refill_cnt", 32'(refill_cnt), 32'd4);

        // Stray refill response in IDLE, stray fetch during MISS_WAIT.
        bus.refill_resp_valid = 1'b1;
        bus.refill_resp_data  = {4{32'hDEAD_BEEF}};
        @(negedge clk);
        bus.refill_resp_valid = 1'b0;
        bus.refill_resp_data  = '0;
        repeat (2) @(negedge clk);
        fetch(32'h0000_0108, 0, 1'b0);
        chk("stray_idle_hit_data", last_resp, 32'hC0DE_0108);
        fetch(32'h0000_2040, 4, 1'b1);
        chk("stray_wait_resp_cnt", 32'(resp_cnt), 32'd7);
        chk("stray_wait_refill_cnt", 32'(refill_cnt), 32'd5);
        fetch(32'h0000_0106, 0, 1'b0);
        chk("low_bits_ignored", last_resp, 32'hC0DE_0104);
        chk("line0_kept_refill_cnt", 32'(refill_cnt), 32'd5);

        // Reset in the middle of a refill.
        wait_ready();
        t0 = cyc + 1;
        bus.cpu_req_valid = 1'b1;
        bus.cpu_req_addr  = 32'h0000_0340;
        refill_q.push_back(exp_t'{cyc: t0 + 1, val: 32'h0000_0340});
        @(negedge clk);
        bus.cpu_req_valid = 1'b0;
        while (cyc < t0 + 3) @(negedge clk);
        rst = 1'b1;
        resp_q.delete();
        refill_q.delete();
        model_invalidate();
        @(negedge clk);
        chk("midreset_refill_addr", bus.refill_req_addr, 32'h0);
        chk("midreset_resp_data", bus.cpu_resp_data, 32'h0);
        rst = 1'b0;
        bus.refill_resp_valid = 1'b1;
        bus.refill_resp_data  = mem_line(32'h0000_0340);
        @(negedge clk);
        bus.refill_resp_valid = 1'b0;
        bus.refill_resp_data  = '0;
        repeat (4) @(negedge clk);
        chk("midreset_no_resp", 32'(resp_cnt), 32'd8);
        chk("midreset_refill_cnt", 32'(refill_cnt), 32'd6);
        fetch(32'h0000_0340, 2, 1'b0);
        chk("after_reset_refill_cnt", 32'(refill_cnt), 32'd7);
        chk("after_reset_refill_addr", last_refill, 32'h0000_0340);
        fetch(32'h0000_034C, 0, 1'b0);
        chk("after_reset_hit_data", last_resp, 32'hC0DE_034C);
        chk("final_resp_cnt", 32'(resp_cnt), 32'd10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/icache_direct.md
# icache_direct

Direct-mapped, read-only instruction cache between the fetch stage and the AXI read master. It serves 32-bit instruction fetches from an on-chip line array. On a miss it issues a single line-refill request to the read master's request interface and installs the returned burst line. One outstanding fetch at a time; blocking on miss.

## Interface
Parameters:
- LINE_WORDS, default 4: 32-bit words per line; power of two, ≥2. Must equal the read master's burst length + 1. The refill data width is LINE_WORDS*32.
- NUM_LINES, default 16: number of lines; power of two, ≥2.

Derived fields (ADDR_WIDTH = 32, from the package):
- OFF_W = log2(LINE_WORDS)
- IDX_W = log2(NUM_LINES)
- word offset = addr[2 +: OFF_W]
- index = addr[2+OFF_W +: IDX_W]
- tag = remaining upper bits

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_req_valid  in  1  fetch request; sampled only while cpu_ready=1.
- cpu_req_addr  in  32  fetch byte address; bits [1:0] are ignored.
- cpu_ready  out  1  cache can accept a request this cycle.
- cpu_resp_valid  out  1  one-cycle pulse; cpu_resp_data is valid.
- cpu_resp_data  out  32  fetched instruction word.
- flush  in  1  invalidate all lines (fence.i); sampled only in IDLE.
- refill_req_valid  out  1  one-cycle refill request pulse to the read master.
- refill_req_addr  out  32  line-aligned refill address.
- refill_resp_valid  in  1  one-cycle pulse from the read master; the line is ready.
- refill_resp_data  in  LINE_WORDS*32  refill line; word w occupies bits [w*32 +: 32].

## Operation
Storage:
- Per line: a valid bit, a tag register and LINE_WORDS data words, held in flops.
- Lookup reads combinationally from the stored index.

State machine, with states IDLE, LOOKUP, MISS_REQ, MISS_WAIT:
- IDLE:
  - cpu_ready = !flush.
  - If flush=1: clear all valid bits; stay in IDLE. Flush has priority over cpu_req_valid, and that request is not accepted.
  - Else if cpu_req_valid=1: latch cpu_req_addr into addr_reg; go to LOOKUP.
- LOOKUP:
  - Hit (valid[idx] && tag[idx]==tag(addr_reg)): register cpu_resp_data = line word at offset, set cpu_resp_valid=1 for the next cycle, go to IDLE.
  - Miss: go to MISS_REQ.
- MISS_REQ:
  - Drive refill_req_valid=1 for exactly this one cycle, with refill_req_addr = addr_reg with bits [OFF_W+1:0] cleared.
  - Go to MISS_WAIT.
- MISS_WAIT:
  - Hold refill_req_addr stable; refill_req_valid=0.
  - On refill_resp_valid=1: write refill_resp_data into line idx, set tag[idx] and valid[idx]=1. In the same edge, register cpu_resp_data = refill word at offset and set cpu_resp_valid=1 for the next cycle. Go to IDLE.
- refill_resp_valid outside MISS_WAIT is ignored.
- A refill overwrites whatever line occupies the index; there is no eviction writeback (read-only cache).
- cpu_req_valid outside IDLE is ignored; the requester must hold its request until cpu_ready is sampled high.

## Timing
Reset values:
- State IDLE, all valid bits 0.
- cpu_resp_valid=0, cpu_resp_data=0.
- refill_req_valid=0, refill_req_addr=0, addr_reg=0.
- cpu_ready=1 in the cycle after reset deasserts (combinational from IDLE).

Hit latency:
- Request accepted at edge T0.
- LOOKUP during cycle T0→T1.
- cpu_resp_valid is high for the single cycle after edge T1, i.e. 2 cycles from acceptance.
- The next request can be accepted at edge T2.

Miss latency:
- refill_req_valid is high in cycle T1→T2.
- If refill_resp_valid arrives at edge Tr, cpu_resp_valid is high for the single cycle after Tr.

refill_req_valid handshake:
- refill_req_valid is never high for more than one consecutive cycle. The read master latches on its idle-state sample and would re-issue if the signal were held.

Reset behaviour:
- rst overrides everything, including mid-refill: state returns to IDLE and all lines are invalidated.
- A refill_resp_valid arriving after such a reset is ignored.

Flush: takes effect at the same edge it is sampled; a request in that cycle is not accepted.

## Test plan
- Cold miss (defaults): after reset, fetch 0x0000_0104.
  - Required: refill_req_valid pulses once with refill_req_addr=0x0000_0100.
  - Drive refill_resp_valid with words {W3..W0}={D,C,B,A}. Required: cpu_resp_data=B, and cpu_resp_valid pulses exactly once.
- Hit after fill: fetch 0x0000_010C.
  - Required: no refill request; cpu_resp_data=D exactly 2 cycles after acceptance.
- Conflict eviction: fetch 0x0000_1100, which has the same index 0 and a different tag.
  - Required: a refill to 0x0000_1100.
  - A subsequent fetch of 0x0000_0100 misses again and refills.
- Flush vs request: in IDLE with the line valid, assert flush and cpu_req_valid together.
  - Required: cpu_ready=0 that cycle and the request is not accepted.
  - The next fetch of 0x0000_0100 misses.
- Reset mid-refill: assert rst while in MISS_WAIT, then pulse refill_resp_valid.
  - Required: no cpu_resp_valid.
  - The line stays invalid; a later fetch of the same address issues a new refill.
- Stray inputs: refill_resp_valid in IDLE, and cpu_req_valid during MISS_WAIT.
  - Required: no state change and no responses beyond the pending miss.
